uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART receiver: the receive-side counterpart of the transmitter on the same serial link.
//   Frame: 1 start bit, 8 data bits (LSB first), no parity, 1 stop bit, at the same baud divisor.
//   Received bytes are buffered in a circular FIFO that the core/peripheral bus drains via re_i.
// PARAMETERS
//   DEPTH  32  FIFO entries; power of 2, >= 2. All DEPTH entries are usable.
// PORTS
//   clk_i         in   1      system clock
//   rst_i         in   1      reset; asynchronous, active-high
//   baud_div_i    in   16     bit period P = baud_div_i+1 clk cycles; must be >= 3; stable while a frame is in progress
//   rx_i          in   1      serial line, asynchronous to clk_i, idle high
//   re_i          in   1      pop head byte; ignored when empty_o=1
//   clr_i         in   1      clears overrun_o
//   data_o        out  8      FIFO head byte (first-word fall-through); valid only when empty_o=0
//   empty_o       out  1      FIFO empty
//   full_o        out  1      FIFO holds DEPTH bytes
//   overrun_o     out  1      sticky: a received byte was dropped because the FIFO was full
//   frame_err_o   out  1      1-cycle pulse: stop bit sampled low, byte discarded
// BEHAVIOUR
//   Reset (async assert): state=IDLE, FIFO empty (rd/wr ptrs and count = 0), both synchroniser flops = 1,
//     empty_o=1, full_o=0, overrun_o=0, frame_err_o=0. data_o after reset is don't-care.
//   Synchroniser: rx_i -> 2 flops -> rx_s. All decisions use rx_s only (2-cycle input latency).
//   16-bit counter cnt; 3-bit bit index; 8-bit shift register.
//   FSM states:
//     IDLE:  rx_s=0 -> cnt<=0, START. Otherwise stay.
//     START: cnt == baud_div_i>>1 (mid start bit): rx_s=0 -> cnt<=0, idx<=0, DATA;
//            rx_s=1 -> IDLE (glitch rejected, no flag). Else cnt++.
//     DATA:  cnt == baud_div_i: shift in rx_s at bit[idx], cnt<=0; idx==7 -> STOP, else idx++. Else cnt++.
//     STOP:  cnt == baud_div_i: rx_s=1 -> push byte; rx_s=0 -> frame_err_o=1 next cycle, no push.
//            Either case -> IDLE. Else cnt++.
//   Back-to-back frames: IDLE reached mid stop bit, so a start edge immediately following is caught.
//   FIFO:
//     push accepted when count<DEPTH, or count==DEPTH with re_i=1 in the same cycle (pop frees the slot).
//     push rejected when full and re_i=0: byte dropped, overrun_o<=1 (held until clr_i or reset).
//     clr_i and a new overrun in the same cycle: overrun_o=1 (set wins).
//     pop: re_i=1 and empty_o=0 -> rd_ptr++. Pop and push same cycle on non-empty FIFO: count unchanged.
//     Pointers wrap modulo DEPTH. full_o/empty_o derived from count (count==DEPTH / count==0), registered updates.
//     Pushed byte visible on data_o/empty_o the cycle after the stop-bit sample edge.
//   baud_div_i change mid-frame: undefined result for that frame only; next frame correct.
//   Reset mid-frame: partial byte discarded, FIFO contents lost, no flag raised.
// TESTING
//   1. baud_div_i=15, drive frame 0xA5 (P=16 cycles/bit) -> data_o=0xA5, empty_o=0 one cycle after stop
//      sample; re_i pulse -> empty_o=1.
//   2. Loopback from the transmitter at baud_div_i=3, bytes 0x00,0xFF,0x55,0x81 back-to-back -> same
//      four bytes popped in order, no frame_err_o, no overrun_o.
//   3. baud_div_i=15, rx_i low for 4 cycles then high -> START aborts to IDLE, empty_o stays 1, no flags.
//   4. Frame 0x3C with stop bit driven 0 -> frame_err_o high exactly 1 cycle, empty_o stays 1;
//      next valid frame 0x42 received normally.
//   5. 33 frames 0x00..0x20 with no reads -> full_o=1 after 32nd, overrun_o=1 after 33rd, pops return
//      0x00..0x1F; clr_i -> overrun_o=0. Repeat with re_i pulsed on the 33rd push cycle -> 0x20 accepted,
//      overrun_o stays 0.
//   6. Assert rst_i mid DATA of frame 0x99, then send 0x66 -> only 0x66 received, all flags 0.

Source files
------------

// File: rtl/uart_rx_if.sv
// Bus-side view of the UART receiver: FIFO drain, status and error flags.
// The design takes the slave modport; the bus master drives re_i/clr_i.
interface uart_rx_if;
  logic       re_i;
  logic       clr_i;
  logic [7:0] data_o;
  logic       empty_o;
  logic       full_o;
  logic       overrun_o;
  logic       frame_err_o;

  modport slave (
    input  re_i,
    input  clr_i,
    output data_o,
    output empty_o,
    output full_o,
    output overrun_o,
    output frame_err_o
  );

  modport master (
    output re_i,
    output clr_i,
    input  data_o,
    input  empty_o,
    input  full_o,
    input  overrun_o,
    input  frame_err_o
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, mid-bit sampling, circular receive FIFO.
// Bytes fall through to data_o; overrun is sticky, frame error pulses.
module uart_rx #(
  parameter int DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] baud_div_i,
  input  logic        rx_i,
  uart_rx_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          rx_q1;
  logic          rx_s;
  logic [1:0]    state;
  logic [15:0]   cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          fe_q;
  logic          ovr_q;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          bit_end;
  logic          push;
  logic          pop;
  logic          push_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx_i;
      rx_s  <= rx_q1;
    end
  end

  assign bit_end = (cnt == baud_div_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      fe_q  <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          // Re-check the line at mid start bit to reject glitches.
          if (cnt == (baud_div_i >> 1)) begin
            cnt <= '0;
            idx <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            sh[idx] <= rx_s;
            cnt     <= '0;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            fe_q  <= !rx_s;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push    = (state == STOP) && bit_end && rx_s;
  assign pop     = bus.re_i && (count != '0);
  // A simultaneous pop frees the slot a full FIFO needs.
  assign push_ok = push && ((count != FULL_CNT) || pop);

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= sh;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{AW{1'b0}}, push_ok}
             - {{AW{1'b0}}, pop};
      if (push && !push_ok) ovr_q <= 1'b1;
      else if (bus.clr_i)   ovr_q <= 1'b0;
    end
  end

  assign bus.data_o      = mem[rd_ptr];
  assign bus.empty_o     = (count == '0);
  assign bus.full_o      = (count == FULL_CNT);
  assign bus.overrun_o   = ovr_q;
  assign bus.frame_err_o = fe_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit,
// FIFO contents, flags and timing checked against hand-derived values.
module tb_uart_rx;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud;
  logic        rx;
  int          checks   = 0;
  int          failures = 0;
  int          fe_cnt   = 0;

  uart_rx_if bus ();

  uart_rx #(.DEPTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .baud_div_i (baud),
    .rx_i       (rx),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_err_o === 1'b1) fe_cnt++;
  end

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic hold(logic v, int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(logic [7:0] b, logic stop, int tail);
    int p;
    p = int'(baud) + 1;
    hold(1'b0, p);
    for (int i = 0; i < 8; i++) hold(b[i], p);
    hold(stop, tail);
  endtask

  task automatic pop_chk(string tag, logic [7:0] want);
    chk({tag, "_ne"}, 16'(bus.empty_o), 16'd0);
    chk(tag, 16'(bus.data_o), 16'(want));
    bus.re_i = 1'b1;
    @(negedge clk);
    bus.re_i = 1'b0;
  endtask

  initial begin
    rx        = 1'b1;
    rst       = 1'b1;
    baud      = 16'd15;
    bus.re_i  = 1'b0;
    bus.clr_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", 16'(bus.empty_o), 16'd1);
    chk("rst_full", 16'(bus.full_o), 16'd0);
    chk("rst_ovr", 16'(bus.overrun_o), 16'd0);
    chk("rst_fe", 16'(bus.frame_err_o), 16'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // P=16, half=7: stop sampled at edge 4+7+9*16 = 155
    send(8'hA5, 1'b1, 10);
    chk("t1_pre_empty", 16'(bus.empty_o), 16'd1);
    @(negedge clk);
    chk("t1_empty", 16'(bus.empty_o), 16'd0);
    chk("t1_data", 16'(bus.data_o), 16'h00A5);
    hold(1'b1, 9);
    bus.re_i = 1'b1;
    @(negedge clk);
    bus.re_i = 1'b0;
    chk("t1_popped", 16'(bus.empty_o), 16'd1);

    baud = 16'd3;
    hold(1'b1, 8);
    send(8'h00, 1'b1, 4);
    send(8'hFF, 1'b1, 4);
    send(8'h55, 1'b1, 4);
    send(8'h81, 1'b1, 4);
    hold(1'b1, 20);
    pop_chk("t2_b0", 8'h00);
    pop_chk("t2_b1", 8'hFF);
    pop_chk("t2_b2", 8'h55);
    pop_chk("t2_b3", 8'h81);
    chk("t2_empty", 16'(bus.empty_o), 16'd1);
    chk("t2_fe", 16'(fe_cnt), 16'd0);
    chk("t2_ovr", 16'(bus.overrun_o), 16'd0);

    baud = 16'd15;
    hold(1'b0, 4);
    hold(1'b1, 60);
    chk("t3_empty", 16'(bus.empty_o), 16'd1);
    chk("t3_fe", 16'(fe_cnt), 16'd0);
    chk("t3_ovr", 16'(bus.overrun_o), 16'd0);

    send(8'h3C, 1'b0, 16);
    hold(1'b1, 16);
    chk("t4_fe_pulse", 16'(fe_cnt), 16'd1);
    chk("t4_empty", 16'(bus.empty_o), 16'd1);
    send(8'h42, 1'b1, 16);
    hold(1'b1, 4);
    pop_chk("t4_next", 8'h42);
    chk("t4_empty2", 16'(bus.empty_o), 16'd1);

    baud = 16'd3;
    hold(1'b1, 8);
    for (int i = 0; i < 32; i++) send(8'(i), 1'b1, 4);
    hold(1'b1, 8);
    chk("t5_full", 16'(bus.full_o), 16'd1);
    chk("t5_ovr0", 16'(bus.overrun_o), 16'd0);
    send(8'h20, 1'b1, 4);
    hold(1'b1, 8);
    chk("t5_ovr1", 16'(bus.overrun_o), 16'd1);
    chk("t5_full2", 16'(bus.full_o), 16'd1);
    for (int i = 0; i < 32; i++) pop_chk("t5_pop", 8'(i));
    chk("t5_empty", 16'(bus.empty_o), 16'd1);
    chk("t5_ovr_sticky", 16'(bus.overrun_o), 16'd1);
    bus.clr_i = 1'b1;
    @(negedge clk);
    bus.clr_i = 1'b0;
    chk("t5_clr", 16'(bus.overrun_o), 16'd0);

    for (int i = 0; i < 32; i++) send(8'(i), 1'b1, 4);
    // P=4, half=1: stop of the 33rd frame sampled at edge 4+1+36 = 41
    send(8'h20, 1'b1, 4);
    bus.re_i = 1'b1;
    @(negedge clk);
    bus.re_i = 1'b0;
    chk("t5b_full", 16'(bus.full_o), 16'd1);
    chk("t5b_ovr", 16'(bus.overrun_o), 16'd0);
    hold(1'b1, 8);
    for (int i = 1; i <= 32; i++) pop_chk("t5b_pop", 8'(i));
    chk("t5b_empty", 16'(bus.empty_o), 16'd1);
    chk("t5b_ovr2", 16'(bus.overrun_o), 16'd0);

    baud = 16'd15;
    hold(1'b1, 8);
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 16);
    hold(1'b0, 16);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    chk("t6_rst_empty", 16'(bus.empty_o), 16'd1);
    rst = 1'b0;
    hold(1'b1, 20);
    send(8'h66, 1'b1, 16);
    hold(1'b1, 4);
    chk("t6_full", 16'(bus.full_o), 16'd0);
    chk("t6_ovr", 16'(bus.overrun_o), 16'd0);
    pop_chk("t6_data", 8'h66);
    chk("t6_empty", 16'(bus.empty_o), 16'd1);
    chk("t6_fe", 16'(fe_cnt), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
